// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary pointer conversion and pointer sizing.
// Converters work on zero-extended pointers of any width up to PTR_MAXW.
package fifo_pkg;

    localparam int PTR_MAXW = 32;

    // Pointer carries one extra wrap bit beyond the address width.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [PTR_MAXW-1:0] bin2gray(input logic [PTR_MAXW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero upper bits decode to zero, so narrower pointers round-trip unchanged.
    function automatic logic [PTR_MAXW-1:0] gray2bin(input logic [PTR_MAXW-1:0] g);
        logic [PTR_MAXW-1:0] b;
        b = '0;
        for (int i = 0; i < PTR_MAXW; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer/full controller: 1-cycle registered status from w_en or wsync_ptr2 change.
// Writes while full are dropped (no pointer move, no ack) and flagged on sticky w_ovf.
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = DEPTH - 2,
    localparam int AW          = ptr_width(DEPTH) - 1
) (
    input  logic          w_clk,
    input  logic          rst,
    input  logic          w_en,
    input  logic [AW:0]   wsync_ptr2,
    input  logic          ovf_clr,
    output logic [AW-1:0] w_addr,
    output logic [AW:0]   wptr,
    output logic          w_full,
    output logic          w_afull,
    output logic [AW:0]   w_level,
    output logic          w_ack,
    output logic          w_ovf
);

    localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL_THRESH);

    logic [AW:0] wbin;
    logic [AW:0] wbin_next;
    logic [AW:0] wgray_next;
    logic [AW:0] rbin;
    logic [AW:0] full_cmp;
    logic [AW:0] level_next;
    logic        accept;
    logic        full_next;
    logic        afull_next;

    assign w_addr = wbin[AW-1:0];

    always_comb begin
        accept     = w_en & ~w_full;
        wbin_next  = wbin + {{AW{1'b0}}, accept};
        wgray_next = (AW+1)'(bin2gray(PTR_MAXW'(wbin_next)));
        rbin       = (AW+1)'(gray2bin(PTR_MAXW'(wsync_ptr2)));
        // Full when write pointer is exactly one lap ahead: Gray form flips the top two bits.
        full_cmp   = {~wsync_ptr2[AW:AW-1], wsync_ptr2[AW-2:0]};
        full_next  = (wgray_next == full_cmp);
        level_next = wbin_next - rbin;
        afull_next = (level_next >= AFULL_LVL);
    end

    always_ff @(posedge w_clk) begin
        if (rst) begin
            wbin    <= '0;
            wptr    <= '0;
            w_full  <= 1'b0;
            w_afull <= 1'b0;
            w_level <= '0;
            w_ack   <= 1'b0;
            w_ovf   <= 1'b0;
        end else begin
            wbin    <= wbin_next;
            wptr    <= wgray_next;
            w_full  <= full_next;
            w_afull <= afull_next;
            w_level <= level_next;
            w_ack   <= accept;
            if (w_en & w_full) begin
                w_ovf <= 1'b1;
            end else if (ovf_clr) begin
                w_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Randomized and directed checks of wptr_full_ctrl against a count-based FIFO occupancy model.
module tb_wptr_full_ctrl;

    logic       w_clk;
    logic       rst;
    logic       w_en;
    logic [4:0] wsync_ptr2;
    logic       ovf_clr;
    logic [3:0] w_addr;
    logic [4:0] wptr;
    logic       w_full;
    logic       w_afull;
    logic [4:0] w_level;
    logic       w_ack;
    logic       w_ovf;

    int total = 0;
    int bad   = 0;

    // Model: counts of writes/reads modulo twice the depth.
    int m_wcnt  = 0;
    int m_level = 0;
    bit m_full  = 0;
    bit m_afull = 0;
    bit m_ack   = 0;
    bit m_ovf   = 0;

    logic [17:0] dut_vec;
    assign dut_vec = {w_addr, wptr, w_full, w_afull, w_level, w_ack, w_ovf};

    wptr_full_ctrl #(.DEPTH(16), .AFULL_THRESH(14)) dut (
        .w_clk      (w_clk),
        .rst        (rst),
        .w_en       (w_en),
        .wsync_ptr2 (wsync_ptr2),
        .ovf_clr    (ovf_clr),
        .w_addr     (w_addr),
        .wptr       (wptr),
        .w_full     (w_full),
        .w_afull    (w_afull),
        .w_level    (w_level),
        .w_ack      (w_ack),
        .w_ovf      (w_ovf)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    // Gray decode by search: the count whose reflected code matches.
    function automatic int gray_to_int(input logic [4:0] g);
        for (int c = 0; c < 32; c++) begin
            logic [4:0] cc;
            cc = 5'(c);
            if ((cc ^ (cc >> 1)) == g) return c;
        end
        return 0;
    endfunction

    function automatic logic [17:0] exp_vec();
        logic [4:0] wc;
        wc = 5'(m_wcnt);
        return {wc[3:0], wc ^ (wc >> 1), m_full, m_afull, 5'(m_level), m_ack, m_ovf};
    endfunction

    task automatic step(input bit en, input logic [4:0] rg, input bit clr, input bit rs);
        bit acc;
        w_en = en; wsync_ptr2 = rg; ovf_clr = clr; rst = rs;
        if (rs) begin
            m_wcnt = 0; m_level = 0; m_full = 0; m_afull = 0; m_ack = 0; m_ovf = 0;
        end else begin
            acc = en && !m_full;
            if (en && m_full) m_ovf = 1;
            else if (clr) m_ovf = 0;
            m_wcnt  = (m_wcnt + int'(acc)) % 32;
            m_level = (m_wcnt - gray_to_int(rg) + 32) % 32;
            m_full  = (m_level == 16);
            m_afull = (m_level >= 14);
            m_ack   = acc;
        end
        @(posedge w_clk);
        #1;
    endtask

    task automatic test_reset();
        step(0, 5'd0, 0, 1);
        step(0, 5'd0, 0, 1);
        total++;
        if (dut_vec !== 18'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", dut_vec);
        end
        step(0, 5'd0, 0, 0);
        total++;
        if (w_full !== 1'b0 || dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL reset_release got=%h want=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_fill();
        int acks;
        acks = 0;
        for (int k = 1; k <= 16; k++) begin
            step(1, 5'd0, 0, 0);
            acks += int'(w_ack);
            total++;
            if (w_afull !== (k >= 14) || w_full !== (k == 16)) begin
                bad++;
                $display("FAIL fill_flags write=%0d afull=%b full=%b want afull=%b full=%b",
                         k, w_afull, w_full, k >= 14, k == 16);
            end
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL fill_model write=%0d got=%h want=%h", k, dut_vec, exp_vec());
            end
        end
        total++;
        if (wptr !== 5'b11000 || w_level !== 5'd16 || acks != 16) begin
            bad++;
            $display("FAIL fill_end wptr=%b level=%0d acks=%0d want 11000/16/16", wptr, w_level, acks);
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 3; k++) begin
            step(1, 5'd0, 0, 0);
            total++;
            if (wptr !== 5'b11000 || w_ack !== 1'b0 || w_ovf !== 1'b1) begin
                bad++;
                $display("FAIL ovf_hold cyc=%0d wptr=%b ack=%b ovf=%b want 11000/0/1", k, wptr, w_ack, w_ovf);
            end
        end
        step(0, 5'd0, 1, 0);
        total++;
        if (w_ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear got=%b want=0", w_ovf);
        end
        step(1, 5'd0, 1, 0);
        total++;
        if (w_ovf !== 1'b1 || dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL ovf_set_wins got=%h want=%h", dut_vec, exp_vec());
        end
        step(0, 5'd0, 1, 0);
    endtask

    task automatic test_read_advance();
        step(0, 5'b00001, 0, 0);
        total++;
        if (w_full !== 1'b0 || w_level !== 5'd15 || w_afull !== 1'b1) begin
            bad++;
            $display("FAIL read_adv full=%b level=%0d afull=%b want 0/15/1", w_full, w_level, w_afull);
        end
    endtask

    task automatic test_wrap();
        logic [4:0] dly0, dly1, prev_ptr;
        logic [3:0] prev_addr;
        int wraps;
        bit onebit_ok, full_seen;
        step(0, 5'd0, 0, 1);
        dly0 = 0; dly1 = 0; wraps = 0; onebit_ok = 1; full_seen = 0;
        for (int k = 0; k < 40; k++) begin
            prev_ptr  = wptr;
            prev_addr = w_addr;
            step(1, dly1, 0, 0);
            dly1 = dly0;
            dly0 = wptr;
            if (prev_addr == 4'd15 && w_addr == 4'd0) wraps++;
            if ($countones(prev_ptr ^ wptr) != 1) onebit_ok = 0;
            if (w_full) full_seen = 1;
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL wrap_model write=%0d got=%h want=%h", k, dut_vec, exp_vec());
            end
        end
        total++;
        if (wraps != 2 || !onebit_ok || full_seen) begin
            bad++;
            $display("FAIL wrap_summary wraps=%0d onebit=%b full_seen=%b want 2/1/0", wraps, onebit_ok, full_seen);
        end
    endtask

    task automatic test_reset_mid();
        step(0, 5'd0, 0, 1);
        for (int k = 0; k < 9; k++) step(1, 5'd0, 0, 0);
        step(1, 5'd0, 1, 1);
        total++;
        if (dut_vec !== 18'd0) begin
            bad++;
            $display("FAIL mid_reset got=%h want=0", dut_vec);
        end
        step(1, 5'd0, 0, 0);
        total++;
        if (w_ack !== 1'b1 || w_addr !== 4'd1 || dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL post_reset_write got=%h want=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [4:0] dly0, dly1;
        int rcnt;
        bit en, clr;
        step(0, 5'd0, 0, 1);
        dly0 = 0; dly1 = 0; rcnt = 0;
        for (int k = 0; k < 500; k++) begin
            en  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0 && rcnt != gray_to_int(dly1)) rcnt = (rcnt + 1) % 32;
            step(en, 5'(rcnt) ^ (5'(rcnt) >> 1), clr, 0);
            dly1 = dly0;
            dly0 = wptr;
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h want=%h", k, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        w_en = 0; wsync_ptr2 = 0; ovf_clr = 0; rst = 1;
        test_reset();
        test_fill();
        test_overflow();
        test_read_advance();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
